tick_debounce: RTL and testbench
================================

# tick_debounce

Tick-driven push-button debouncer and edge detector that consumes the one-cycle `tick` strobe produced by the clock divider, using it as its sample enable. It sits between a raw board button pin and user logic. It produces a clean level, single-cycle press and release pulses, and an optional long-press pulse. All debounce timing is expressed in ticks, so the divider's `TICK_HZ` sets the sample period.

## Interface
- `STABLE_TICKS`, default 4: consecutive differing samples required to accept a change; must be ≥1.
- `LONG_TICKS`, default 100: ticks a press must be held before `long` fires; must be ≥1.
- `ACTIVE_LOW`, default 1: 1 means the pin reads 0 when pressed.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  sample strobe, high for one `clk` cycle; may be tied high.
- `btn_in`  in  1  raw asynchronous button pin.
- `level`  out  1  debounced pressed state (1 = pressed).
- `press`  out  1  one-cycle pulse when a press is accepted.
- `release`  out  1  one-cycle pulse when a release is accepted.
- `long`  out  1  one-cycle pulse, at most once per press.

## Operation
- **Synchronizer:** 2-flop synchronizer on `btn_in`, clocked every `clk` and not gated by `tick`. `raw = sync_out ^ ACTIVE_LOW`, where 1 means pressed.
- **Debounce counter:** `cnt` has width `$clog2(STABLE_TICKS+1)` and advances only on cycles where `tick`=1.
  - If `raw == level`: `cnt <= 0`.
  - Else if `cnt == STABLE_TICKS-1`: `level <= raw`, `cnt <= 0`, and pulse `press` if `raw`=1, otherwise pulse `release`.
  - Else: `cnt <= cnt + 1`.
  - Any sample agreeing with `level` restarts the count, so a glitch fully cancels progress.
- **Hold state machine:** states IDLE, PRESSED, HELD.
  - IDLE → PRESSED on press acceptance; `hold_cnt <= 0`. The accepting tick is not counted toward the hold.
  - PRESSED, on a tick with no release accepted: if `hold_cnt == LONG_TICKS-1`, pulse `long` and go to HELD; otherwise `hold_cnt++`.
  - PRESSED or HELD → IDLE on release acceptance.
  - HELD: `hold_cnt` frozen; no further `long` until the next press.
- **Priority:** if release acceptance and `long` would occur on the same tick, release wins and `long` is not asserted.
- **Pulse behaviour:** `press`, `release` and `long` are registered and deassert on the next `clk` cycle regardless of `tick`.

## Timing
- **Reset values:** while `rst`=1 and on the first cycle after it:
  - `level`=0, `press`=`release`=`long`=0.
  - `cnt`=0, `hold_cnt`=0, state IDLE.
  - Synchronizer flops load the idle pin value (`ACTIVE_LOW`), so no spurious change is seen after reset.
- **Latency:** 2 `clk` cycles of synchronization, then `STABLE_TICKS` ticks. `level` changes and the pulse asserts in the `clk` cycle after the accepting tick edge.
- **`tick` tied high:** debounce runs in `clk` cycles. A stable press gives `press` exactly 2+`STABLE_TICKS` cycles after the `btn_in` edge, ±1 cycle for sampling phase.
- **`STABLE_TICKS`=1:** change accepted on the first differing tick.
- **Reset mid-operation:** all progress is discarded. A button held through reset is re-accepted as a fresh press `STABLE_TICKS` ticks after synchronization following deassert.
- **Saturation:** `hold_cnt` never wraps; it stops counting in HELD.

## Configuration
- Macro `TICK_DEBOUNCE_LONGPRESS_EN`.
- **Defined:** hold state machine, `hold_cnt` and the `long` output behave as above.
- **Undefined:**
  - `long` is tied to constant 0.
  - Hold state machine and `hold_cnt` are not instantiated.
  - `LONG_TICKS` is ignored.
  - `level`, `press` and `release` behave identically to the defined case.

## Test plan
Benches use `STABLE_TICKS`=4, `LONG_TICKS`=10, `ACTIVE_LOW`=1 and `tick` every 8 `clk` cycles unless stated otherwise.

1. Reset with `btn_in`=1 held idle for 200 cycles → `level`=0; `press`, `release` and `long` never assert.
2. Drive `btn_in` 1→0 and hold → exactly one `press` pulse, one cycle wide, on the cycle after the 4th tick that samples pressed; `level`=1 from that cycle. Release (`btn_in`=1) → one `release` pulse 4 ticks later; `level`=0.
3. Bounce `btn_in` as 0 for 3 ticks, 1 for 1 tick, repeated 10 times → no `press`; `level` stays 0. Same test with `tick` tied high and bounce periods counted in cycles → same result.
4. Hold the press for 15 ticks after `press` → a single `long` pulse exactly 10 ticks after the `press` tick, and no second `long`. Release → `release` pulse; hold again → a fresh `long` fires again.
5. Time the release so it is accepted on what would be the 10th hold tick → `release` pulses, `long` never asserts, state returns to IDLE.
6. Assert `rst` for 3 cycles while `btn_in`=0 is held and `level`=1 → all outputs 0 on the cycle after assert. `press` re-fires 4 ticks after `rst` deasserts, and `long` 10 ticks after that. Also rebuild without `TICK_DEBOUNCE_LONGPRESS_EN` → `long` stays 0 throughout scenario 4.

Source files
------------

// File: rtl/tick_debounce.sv
// tick_debounce
//   Push-button debouncer and edge detector sampled on a one-cycle tick strobe.
//   The raw pin goes through a 2-flop synchronizer that runs every clk. A change
//   is accepted after STABLE_TICKS consecutive tick samples that differ from the
//   debounced level. Any agreeing sample cancels all progress.
//   Optional long-press detection is enabled with `define TICK_DEBOUNCE_LONGPRESS_EN.
//
// Parameters
//   STABLE_TICKS  consecutive differing samples needed to accept a change (>=1)
//   LONG_TICKS    ticks a press must be held before long fires (>=1)
//   ACTIVE_LOW    1: pin reads 0 when pressed
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   tick      sample strobe, one clk wide (may be tied high)
//   btn_in    raw asynchronous button pin
//   level     debounced pressed state (1 = pressed)
//   press     one-cycle pulse when a press is accepted
//   released  one-cycle pulse when a release is accepted
//             ("release" is a reserved word in SystemVerilog)
//   long      one-cycle pulse once per press after LONG_TICKS held ticks
module tick_debounce #(
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned LONG_TICKS   = 100,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic released,
  output logic long
);

  localparam int unsigned      CW       = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [1:0]    sync;
  logic          raw;
  logic [CW-1:0] cnt;
  logic          accept;

  // Reset loads the idle pin value so no spurious change follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {2{ACTIVE_LOW}};
    end else begin
      sync <= {sync[0], btn_in};
    end
  end

  assign raw    = sync[1] ^ ACTIVE_LOW;
  assign accept = tick && (raw != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      level    <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      press    <= 1'b0;
      released <= 1'b0;
      if (tick) begin
        if (raw == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= raw;
          cnt   <= '0;
          if (raw) begin
            press <= 1'b1;
          end else begin
            released <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef TICK_DEBOUNCE_LONGPRESS_EN
  localparam int unsigned   HW        = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } hold_state_t;

  hold_state_t   state;
  logic [HW-1:0] hold_cnt;

  // Release acceptance is checked before the hold count, so a release landing
  // on the final hold tick suppresses long.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      long     <= 1'b0;
    end else begin
      long <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && raw) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (accept && !raw) begin
            state <= IDLE;
          end else if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              long  <= 1'b1;
              state <= HELD;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        HELD: begin
          if (accept && !raw) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // LONG_TICKS has no effect in this build; it is referenced only so the
  // parameter stays consumed.
  localparam bit LONG_UNUSED = (LONG_TICKS == 0);
  assign long = 1'b0 & LONG_UNUSED;
`endif

endmodule

// File: tb/tb_tick_debounce.sv
module tb_tick_debounce;

  localparam int unsigned ST = 4;
  localparam int unsigned LT = 10;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic btn_in;
  logic level;
  logic press;
  logic released;
  logic long;

  always #5 clk = ~clk;

  tick_debounce #(
    .STABLE_TICKS(ST),
    .LONG_TICKS  (LT),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .btn_in  (btn_in),
    .level   (level),
    .press   (press),
    .released(released),
    .long    (long)
  );

  typedef struct {
    int unsigned cyc;
    logic [2:0]  ev;   // {long, released, press}
  } exp_t;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  bit          chk_en = 1'b0;
  int unsigned tick_period = 8;

  // Tick strobe: every tick_period cycles, or every cycle when period is 1.
  initial begin
    int unsigned tc;
    tc   = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (tick_period <= 1) || (tc % tick_period == 0);
      tc++;
    end
  end

  // Reference model: pin is seen two clock edges late; a change is accepted
  // when the last ST tick samples all disagree with the current level. Long
  // fires LT ticks after the press tick unless a release was accepted first.
  logic        d0 = 1'b1;
  logic        d1 = 1'b1;
  logic        m_level = 1'b0;
  logic        win[$];
  int unsigned tick_no = 0;
  int unsigned press_tick = 0;
  bit          armed = 1'b0;

  always @(posedge clk) begin : model
    logic       raw;
    logic [2:0] ev;
    bit         differ;
    cyc++;
    ev = 3'b000;
    if (rst === 1'b1) begin
      chk_en  = 1'b1;
      d0      = 1'b1;
      d1      = 1'b1;
      m_level = 1'b0;
      win.delete();
      armed   = 1'b0;
    end else if (chk_en) begin
      raw = ~d1;
      if (tick === 1'b1) begin
        tick_no++;
        win.push_back(raw);
        if (win.size() > ST) void'(win.pop_front());
        if (win.size() == ST) begin
          differ = 1'b1;
          foreach (win[i]) if (win[i] == m_level) differ = 1'b0;
          if (differ) begin
            m_level = raw;
            ev      = raw ? 3'b001 : 3'b010;
            win.delete();
            armed   = raw;
            if (raw) press_tick = tick_no;
          end
        end
`ifdef TICK_DEBOUNCE_LONGPRESS_EN
        if (armed && (tick_no - press_tick == LT)) begin
          ev    = 3'b100;
          armed = 1'b0;
        end
`endif
      end
      d1 = d0;
      d0 = btn_in;
      if (ev != 3'b000) q.push_back('{cyc, ev});
    end
  end

  // Monitor: compares every presented pulse against the scoreboard head and
  // the level output against the model every cycle.
  always @(negedge clk) begin : monitor
    logic [2:0] got;
    logic [2:0] want;
    if (chk_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL missing_pulse: cyc %0d got nothing, required ev=%b at cyc %0d",
                 cyc, q[0].ev, q[0].cyc);
        void'(q.pop_front());
      end
      got  = {long, released, press};
      want = (q.size() > 0 && q[0].cyc == cyc) ? q[0].ev : 3'b000;
      if (got !== 3'b000 || want != 3'b000) begin
        n_cmp++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL pulse: cyc %0d {long,rel,press} got=%b required=%b", cyc, got, want);
        end
        if (want != 3'b000) void'(q.pop_front());
      end
      n_cmp++;
      if (level !== m_level) begin
        n_fail++;
        $display("FAIL level: cyc %0d got=%b required=%b", cyc, level, m_level);
      end
    end
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_ticks(input logic v, input int unsigned n);
    btn_in = v;
    wait_cyc(n * tick_period);
  endtask

  task automatic wait_press();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (press === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL press_timeout: got no press within 200 cycles, required one");
    end
  endtask

  initial begin
    int unsigned offs[3];
    offs   = '{45, 53, 61};
    btn_in = 1'b1;
    rst    = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(200);

    // Clean press and release
    hold_ticks(1'b0, 8);
    hold_ticks(1'b1, 8);

    // Bounce: never four agreeing samples in a row
    repeat (10) begin
      hold_ticks(1'b0, 3);
      hold_ticks(1'b1, 1);
    end
    hold_ticks(1'b1, 6);
    tick_period = 1;
    repeat (10) begin
      hold_ticks(1'b0, 3);
      hold_ticks(1'b1, 1);
    end
    hold_ticks(1'b1, 8);
    tick_period = 8;
    wait_cyc(16);

    // Long press, release, second long press
    hold_ticks(1'b0, ST + 15 + 2);
    hold_ticks(1'b1, 8);
    hold_ticks(1'b0, 20);
    hold_ticks(1'b1, 8);

    // Release accepted on hold tick 9, 10 (long suppressed) and 11
    foreach (offs[k]) begin
      btn_in = 1'b0;
      wait_press();
      wait_cyc(offs[k]);
      btn_in = 1'b1;
      wait_cyc(64);
    end

    // Reset while pressed, then re-acceptance of the held button
    hold_ticks(1'b0, 8);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({level, press, released, long} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got {level,press,rel,long}=%b required=0000",
               {level, press, released, long});
    end
    wait_cyc(2);
    rst = 1'b0;
    hold_ticks(1'b0, 20);
    hold_ticks(1'b1, 8);

    // Randomized pin activity, tick rates and occasional resets
    repeat (60) begin
      tick_period = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 8);
      btn_in      = 1'($urandom_range(0, 1));
      wait_cyc($urandom_range(1, 80));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        wait_cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
    end
    btn_in      = 1'b1;
    tick_period = 8;
    wait_cyc(200);

    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pulses still outstanding, required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
